button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/sale_terminal_pkg.sv | 18 +
 rtl/button_event_decoder_if.sv | 21 ++
 rtl/button_event_decoder_edge_detect.sv | 24 ++
 rtl/button_event_decoder.sv | 121 ++++++++++++
 tb/tb_button_event_decoder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/sale_terminal_pkg.sv
// Shared types and constants for the sale-terminal front panel logic:
// button decoder state encoding and default timing constants.
package sale_terminal_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  localparam int DEFAULT_LONG_PRESS_CYCLES = 50_000_000;
  localparam int DEFAULT_REPEAT_CYCLES     = 10_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Switch input and event outputs of the button event decoder.
// The master drives the switch/enable side; the decoder is the slave.
interface button_event_decoder_if;
  logic CleanSWIn;
  logic Enable;
  logic PressPulse;
  logic ReleasePulse;
  logic LongPressPulse;
  logic RepeatPulse;
  logic Held;

  modport master (
    output CleanSWIn, Enable,
    input  PressPulse, ReleasePulse, LongPressPulse, RepeatPulse, Held
  );

  modport slave (
    input  CleanSWIn, Enable,
    output PressPulse, ReleasePulse, LongPressPulse, RepeatPulse, Held
  );
endinterface

// File: rtl/button_event_decoder_edge_detect.sv
// Edge detector for the debounced switch level: keeps the previous sample
// (SwPrev) and flags rising and falling edges combinationally.
module edge_detect (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic sw_prev_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_prev_reg <= 1'b0;
    end else begin
      sw_prev_reg <= din;
    end
  end

  assign rise = din & ~sw_prev_reg;
  assign fall = ~din & sw_prev_reg;

endmodule

// File: rtl/button_event_decoder.sv
// Button event decoder: press / release / long-press pulses and a Held level.
// Define BTN_AUTOREPEAT_EN to enable periodic RepeatPulse while in LONG.
module button_event_decoder
  import sale_terminal_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES
) (
  input logic                   CLK,
  input logic                   RST_N,
  button_event_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(LONG_PRESS_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  localparam int P_PRESS   = 0;
  localparam int P_RELEASE = 1;
  localparam int P_LONG    = 2;
`ifdef BTN_AUTOREPEAT_EN
  localparam int P_REPEAT   = 3;
  localparam int NUM_PULSES = 4;
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`else
  localparam int NUM_PULSES = 3;
`endif

  btn_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [NUM_PULSES-1:0]  pulse_reg, pulse_next;
  logic                   sw_rise;
  logic                   sw_fall;

  edge_detect u_edge_detect (
    .CLK   (CLK),
    .RST_N (RST_N),
    .din   (bus.CleanSWIn),
    .rise  (sw_rise),
    .fall  (sw_fall)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pulse_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
    end
  end

  // Outside IDLE the previous sample is always 1, so a falling edge is
  // exactly "switch low now" -- the release condition.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = '0;
    if (!bus.Enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sw_rise) begin
            pulse_next[P_PRESS] = 1'b1;
            cnt_next            = '0;
            state_next          = PRESSED;
          end
        end
        PRESSED: begin
          if (sw_fall) begin
            pulse_next[P_RELEASE] = 1'b1;
            cnt_next              = '0;
            state_next            = IDLE;
          end else if (cnt_reg == LONG_LAST) begin
            pulse_next[P_LONG] = 1'b1;
            cnt_next           = '0;
            state_next         = LONG;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        LONG: begin
          if (sw_fall) begin
            pulse_next[P_RELEASE] = 1'b1;
            cnt_next              = '0;
            state_next            = IDLE;
          end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (cnt_reg == REPEAT_LAST) begin
              pulse_next[P_REPEAT] = 1'b1;
              cnt_next             = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
`else
            cnt_next = '0;
`endif
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign bus.PressPulse     = pulse_reg[P_PRESS];
  assign bus.ReleasePulse   = pulse_reg[P_RELEASE];
  assign bus.LongPressPulse = pulse_reg[P_LONG];
`ifdef BTN_AUTOREPEAT_EN
  assign bus.RepeatPulse    = pulse_reg[P_REPEAT];
`else
  assign bus.RepeatPulse    = 1'b0;
`endif
  assign bus.Held           = (state_reg != IDLE);

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: driver pushes model expectations,
// monitor pops and compares one output vector per clock.
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int R = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  button_event_decoder_if bus();

  button_event_decoder #(
    .LONG_PRESS_CYCLES (L),
    .REPEAT_CYCLES     (R)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial forever #5 CLK = ~CLK;

  // Expected vector: {press, release, long, repeat, held}
  logic [4:0] exp_q[$];
  logic [4:0] mon_e, mon_g;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a press is tracked with its age in cycles since the press.
  bit m_track = 1'b0;
  bit m_prev  = 1'b0;
  int m_age   = 0;

  function automatic logic [4:0] dut_out();
    return {bus.PressPulse, bus.ReleasePulse, bus.LongPressPulse,
            bus.RepeatPulse, bus.Held};
  endfunction

  task automatic model_step(input bit sw, input bit en);
    logic [4:0] e;
    e = '0;
    if (!en) begin
      m_track = 1'b0;
    end else if (!m_track) begin
      if (sw && !m_prev) begin
        e[4]    = 1'b1;
        m_track = 1'b1;
        m_age   = 0;
      end
    end else if (!sw) begin
      e[3]    = 1'b1;
      m_track = 1'b0;
    end else begin
      m_age++;
      if (m_age == L) e[2] = 1'b1;
      if (AR && m_age > L && ((m_age - L) % R) == 0) e[1] = 1'b1;
    end
    e[0]   = m_track;
    m_prev = sw;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit sw, input bit en);
    @(negedge CLK);
    bus.CleanSWIn = sw;
    bus.Enable    = en;
    model_step(sw, en);
  endtask

  task automatic check_zero(input string name);
    logic [4:0] g;
    g = dut_out();
    total++;
    if (g !== 5'b0) begin
      bad++;
      $display("FAIL %s: got=%b required=00000", name, g);
    end else begin
      $display("%s: outputs cleared", name);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_zero("async_reset");
    m_track = 1'b0;
    m_prev  = 1'b0;
    m_age   = 0;
    repeat (n) @(posedge CLK);
    #2;
    check_zero("reset_hold");
    RST_N = 1'b1;
  endtask

  // Monitor: one comparison per clock whenever an expectation is pending.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (RST_N && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_g = dut_out();
      total++;
      if (mon_g !== mon_e) begin
        bad++;
        $display("FAIL outputs cyc=%0d got=%b required=%b (press,release,long,repeat,held)",
                 cyc, mon_g, mon_e);
      end else if (mon_g[4:1] != 4'b0) begin
        $display("cyc=%0d events=%b held=%b", cyc, mon_g[4:1], mon_g[0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  bit r_sw, r_en;
  int r_len;

  initial begin
    bus.CleanSWIn = 1'b0;
    bus.Enable    = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check_zero("power_on_reset");
    RST_N = 1'b1;

    // Short press: 3 cycles held
    repeat (3) step(1, 1);
    repeat (3) step(0, 1);

    // Long press with repeats
    repeat (20) step(1, 1);
    repeat (3) step(0, 1);

    // Release exactly when the long-press threshold would hit
    repeat (8) step(1, 1);
    repeat (3) step(0, 1);

    // Switch already high when Enable rises
    repeat (3) step(1, 0);
    repeat (4) step(1, 1);
    step(0, 1);
    repeat (2) step(1, 1);
    repeat (2) step(0, 1);

    // Back-to-back press/release
    step(1, 1); step(0, 1); step(1, 1); step(0, 1); step(0, 1);

    // Reset in the middle of LONG, switch still held
    repeat (12) step(1, 1);
    do_reset(2);
    repeat (3) step(1, 1);
    repeat (2) step(0, 1);

    // Enable dropped during a press
    repeat (4) step(1, 1);
    step(1, 0);
    repeat (2) step(0, 1);

    // Randomised segments
    for (int i = 0; i < 450; i++) begin
      r_sw  = 1'($urandom_range(0, 1));
      r_en  = ($urandom_range(0, 9) != 0);
      r_len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 6);
      if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3));
      repeat (r_len) step(r_sw, r_en);
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge CLK);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
